if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-003 The block SHALL have the port stall_i, input, 1 bit: downstream (ID) not ready; freeze all fetch state.
REQ-004 The block SHALL have the port br_taken_i, input, 1 bit: branch/jump redirect from EX.
REQ-005 The block SHALL have the port br_target_i, input, 8 bits: redirect PC value.
REQ-006 The block SHALL have the port imem_addr_o, output, 8 bits: instruction memory address, equal to the current PC.
REQ-007 The block SHALL have the port imem_rdata_i, input, 8 bits: instruction byte at imem_addr_o, combinational read.
REQ-008 The block SHALL have the port ir_o, output, 8 bits: registered instruction; [7:4] opcode, [3:2] rd/ra, [1:0] rb.
REQ-009 The block SHALL have the port regaddrc_o, output, 4 bits: equal to ir_o[3:0], feeding the ID register-address input.
REQ-010 The block SHALL have the port imm_o, output, 8 bits: immediate byte of a two-byte LDI, feeding the ID AorD input.
REQ-011 The block SHALL have the port valid_o, output, 1 bit: ir_o/imm_o hold a complete instruction for ID.
REQ-012 The block SHALL have the port pc_o, output, 8 bits: address of the instruction currently in ir_o.

Function
REQ-013 The PC SHALL be 8 bits, SHALL increment by 1 per byte consumed, and SHALL wrap from 8'hFF to 8'h00 with no flag.
REQ-014 The FSM SHALL have three states: FETCH, IMM and HALT.
REQ-015 In FETCH with stall_i=0, the block SHALL load ir_o from imem_rdata_i, load pc_o with the PC, and advance the PC.
REQ-016 In FETCH, if the fetched opcode is LDI, the block SHALL set valid_o to 0 and go to IMM.
REQ-017 In FETCH, if the fetched opcode is HLT, the block SHALL set valid_o to 1 and go to HALT.
REQ-018 In FETCH, for any other opcode, the block SHALL set valid_o to 1 and stay in FETCH.
REQ-019 In IMM with stall_i=0, the block SHALL load imm_o from imem_rdata_i, advance the PC, set valid_o to 1, and go to FETCH.
REQ-020 In IMM, the block SHALL leave ir_o unchanged.
REQ-021 In HALT, the block SHALL set valid_o to 0 and hold the PC, ir_o and imm_o; it SHALL leave HALT only on reset or br_taken_i.
REQ-022 The fetch latency SHALL be one cycle for a single-byte instruction and two cycles for LDI.
REQ-023 Throughput SHALL be one byte per unstalled cycle.
REQ-024 When stall_i=1 and br_taken_i=0, every register (PC, ir_o, imm_o, pc_o, valid_o, state) SHALL hold its value.
REQ-025 When br_taken_i=1, the block SHALL set the PC to br_target_i, set valid_o to 0 and set the state to FETCH, in any state.
REQ-026 A redirect SHALL take priority over stall_i.
REQ-027 When br_taken_i=1, ir_o and imm_o SHALL hold their values.
REQ-028 A redirect arriving in IMM SHALL abandon the partial LDI, which is never marked valid.
REQ-029 When rst=0 in the same cycle as br_taken_i or stall_i, reset SHALL win.
REQ-030 imem_addr_o and regaddrc_o SHALL be combinational from registers only, with no path from any input.

Reset
REQ-031 On a rising edge of clk with rst=0, the block SHALL set the PC to 8'h00, ir_o to 8'h00, imm_o to 8'h00, pc_o to 8'h00, valid_o to 0 and the state to FETCH.
REQ-032 A reset in the middle of an LDI SHALL discard the partial instruction.
REQ-033 The first fetch SHALL occur on the first rising edge of clk with rst=1.

Structure
REQ-034 A shared package SHALL hold the opcode constants (LDI=4'b1000, HLT=4'b1111), the state encoding (FETCH, IMM, HALT) and the constants XLEN=8 and PC_RESET=8'h00.
REQ-035 The instruction ROM (inst_rom, 256x8, asynchronous read) SHALL be a separate sub-module instantiated beside if_stage at processor top level.
REQ-036 The block SHALL contain no sub-module; the PC incrementer and the FSM are inline.

Verification
REQ-037 The bench SHALL check sequential fetch: ROM[0..2]=8'h15,8'h26,8'h37 with no stall -> valid_o=1 on cycles 1-3, with ir_o=15/26/37, regaddrc_o=5/6/7 and pc_o=0/1/2.
REQ-038 The bench SHALL check LDI: ROM[0]=8'h84, ROM[1]=8'hA5 -> cycle 1 valid_o=0; cycle 2 valid_o=1, ir_o=8'h84, imm_o=8'hA5; next fetch from address 2.
REQ-039 The bench SHALL check stall: stall_i=1 for 3 cycles mid-stream -> all outputs frozen; on release, fetch resumes at the held PC with no skipped or duplicated byte.
REQ-040 The bench SHALL check redirect versus stall: br_taken_i=1, br_target_i=8'h40 and stall_i=1 all in IMM -> next cycle valid_o=0 and imem_addr_o=8'h40; the partial LDI is never marked valid.
REQ-041 The bench SHALL check halt and wrap: HLT at 8'hFF -> one valid cycle with pc_o=8'hFF, then valid_o=0 and imem_addr_o=8'h00 held; a later br_taken_i to 8'h10 resumes fetch there.
REQ-042 The bench SHALL check reset in the middle of an LDI: rst=0 for one cycle during IMM -> PC=0, ir_o=0, imm_o=0 and valid_o=0 on the next cycle.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared fetch-stage definitions: data width, reset PC, the opcodes
// the fetch FSM decodes, and the fetch FSM state encoding.
package if_stage_pkg;

    localparam int          XLEN     = 8;
    localparam logic [7:0]  PC_RESET = 8'h00;

    localparam logic [3:0]  OP_LDI   = 4'b1000;
    localparam logic [3:0]  OP_HLT   = 4'b1111;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        IMM   = 2'd1,
        HALT  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_stage_inst_rom.sv
// 256x8 instruction memory with asynchronous read; the synchronous write
// port lets the processor top (or a loader) preload the program image.
module inst_rom
    import if_stage_pkg::*;
(
    input  logic            clk,
    input  logic            we,
    input  logic [XLEN-1:0] waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] raddr,
    output logic [XLEN-1:0] rdata
);

    logic [XLEN-1:0] mem [0:(1<<XLEN)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: walks the byte-wide instruction stream, assembles
// two-byte LDI instructions, stops on HLT and accepts redirects from EX.
module if_stage
    import if_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            br_taken_i,
    input  logic [XLEN-1:0] br_target_i,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic [XLEN-1:0] ir_o,
    output logic [3:0]      regaddrc_o,
    output logic [XLEN-1:0] imm_o,
    output logic            valid_o,
    output logic [XLEN-1:0] pc_o
);

    logic [XLEN-1:0] pc_p0;
    logic [XLEN-1:0] ir_p1;
    logic [XLEN-1:0] imm_p1;
    logic [XLEN-1:0] pc_p1;
    logic            vld_p1;
    fetch_state_e    state;

    logic [3:0]      fetched_op;
    assign fetched_op = imem_rdata_i[7:4];

    // p0 -> p1: fetch pointer drives memory, fetched byte lands in IR/IMM
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_p0  <= PC_RESET;
            ir_p1  <= '0;
            imm_p1 <= '0;
            pc_p1  <= PC_RESET;
            vld_p1 <= 1'b0;
            state  <= FETCH;
        end else if (br_taken_i) begin
            // redirect beats stall and abandons any half-assembled LDI
            pc_p0  <= br_target_i;
            vld_p1 <= 1'b0;
            state  <= FETCH;
        end else if (!stall_i) begin
            case (state)
                FETCH: begin
                    ir_p1 <= imem_rdata_i;
                    pc_p1 <= pc_p0;
                    pc_p0 <= pc_p0 + 8'd1;
                    if (fetched_op == OP_LDI) begin
                        vld_p1 <= 1'b0;
                        state  <= IMM;
                    end else if (fetched_op == OP_HLT) begin
                        vld_p1 <= 1'b1;
                        state  <= HALT;
                    end else begin
                        vld_p1 <= 1'b1;
                        state  <= FETCH;
                    end
                end
                IMM: begin
                    imm_p1 <= imem_rdata_i;
                    pc_p0  <= pc_p0 + 8'd1;
                    vld_p1 <= 1'b1;
                    state  <= FETCH;
                end
                HALT: begin
                    vld_p1 <= 1'b0;
                end
                default: begin
                    vld_p1 <= 1'b0;
                    state  <= FETCH;
                end
            endcase
        end
    end

    assign imem_addr_o = pc_p0;
    assign ir_o        = ir_p1;
    assign regaddrc_o  = ir_p1[3:0];
    assign imm_o       = imm_p1;
    assign valid_o     = vld_p1;
    assign pc_o        = pc_p1;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: program image in inst_rom, behavioural fetch model
// updated each edge, directed scenarios followed by randomized traffic.
module tb_if_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       stall_i;
    logic       br_taken_i;
    logic [7:0] br_target_i;
    logic [7:0] imem_addr_o;
    logic [7:0] imem_rdata_i;
    logic [7:0] ir_o;
    logic [3:0] regaddrc_o;
    logic [7:0] imm_o;
    logic       valid_o;
    logic [7:0] pc_o;

    logic       rom_we;
    logic [7:0] rom_waddr;
    logic [7:0] rom_wdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    if_stage dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .br_taken_i   (br_taken_i),
        .br_target_i  (br_target_i),
        .imem_addr_o  (imem_addr_o),
        .imem_rdata_i (imem_rdata_i),
        .ir_o         (ir_o),
        .regaddrc_o   (regaddrc_o),
        .imm_o        (imm_o),
        .valid_o      (valid_o),
        .pc_o         (pc_o)
    );

    inst_rom u_rom (
        .clk   (clk),
        .we    (rom_we),
        .waddr (rom_waddr),
        .wdata (rom_wdata),
        .raddr (imem_addr_o),
        .rdata (imem_rdata_i)
    );

    // reference model: program image plus architectural fetch view
    logic [7:0] img [0:255];
    logic [7:0] m_pc, m_ir, m_imm, m_pco;
    logic       m_valid;
    logic       m_wait_imm;
    logic       m_halted;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 8'h00; m_ir = 8'h00; m_imm = 8'h00; m_pco = 8'h00;
        m_valid = 1'b0; m_wait_imm = 1'b0; m_halted = 1'b0;
    endtask

    task automatic model_edge(input logic r, input logic st, input logic br, input logic [7:0] tgt);
        logic [7:0] b;
        if (!r) begin
            model_reset();
        end else if (br) begin
            m_pc = tgt; m_valid = 1'b0; m_wait_imm = 1'b0; m_halted = 1'b0;
        end else if (!st) begin
            b = img[m_pc];
            if (m_halted) begin
                m_valid = 1'b0;
            end else if (m_wait_imm) begin
                m_imm = b; m_pc = m_pc + 8'd1; m_valid = 1'b1; m_wait_imm = 1'b0;
            end else begin
                m_ir = b; m_pco = m_pc; m_pc = m_pc + 8'd1;
                m_wait_imm = (b[7:4] == 4'h8);
                m_halted   = (b[7:4] == 4'hF);
                m_valid    = !m_wait_imm;
            end
        end
    endtask

    task automatic compare_all();
        chk("imem_addr", imem_addr_o, m_pc);
        chk("ir",        ir_o,        m_ir);
        chk("regaddrc",  8'(regaddrc_o), 8'(m_ir[3:0]));
        chk("imm",       imm_o,       m_imm);
        chk("valid",     8'(valid_o), 8'(m_valid));
        chk("pc_o",      pc_o,        m_pco);
    endtask

    // one clock: drive on negedge, model on posedge, compare just after
    task automatic step(input logic r, input logic st, input logic br, input logic [7:0] tgt);
        @(negedge clk);
        rst = r; stall_i = st; br_taken_i = br; br_target_i = tgt;
        @(posedge clk);
        model_edge(r, st, br, tgt);
        #1;
        compare_all();
    endtask

    task automatic rom_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        rst = 1'b0; stall_i = 1'b0; br_taken_i = 1'b0;
        rom_we = 1'b1; rom_waddr = a; rom_wdata = d;
        img[a] = d;
        @(negedge clk);
        rom_we = 1'b0;
        model_reset();
    endtask

    initial begin
        rst = 1'b0; stall_i = 1'b0; br_taken_i = 1'b0; br_target_i = 8'h00;
        rom_we = 1'b0; rom_waddr = 8'h00; rom_wdata = 8'h00;
        model_reset();
        for (int i = 0; i < 256; i++) rom_write(8'(i), 8'h00);

        // reset state
        step(1'b0, 1'b1, 1'b1, 8'h77);
        chk("rst_valid", 8'(valid_o), 8'h00);
        chk("rst_addr",  imem_addr_o, 8'h00);

        // sequential fetch
        rom_write(8'h00, 8'h15); rom_write(8'h01, 8'h26); rom_write(8'h02, 8'h37);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk("seq_ir0", ir_o, 8'h15); chk("seq_rc0", 8'(regaddrc_o), 8'h05);
        chk("seq_pc0", pc_o, 8'h00); chk("seq_v0", 8'(valid_o), 8'h01);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk("seq_ir1", ir_o, 8'h26); chk("seq_pc1", pc_o, 8'h01);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk("seq_ir2", ir_o, 8'h37); chk("seq_rc2", 8'(regaddrc_o), 8'h07);
        chk("seq_pc2", pc_o, 8'h02);

        // LDI assembly
        rom_write(8'h00, 8'h84); rom_write(8'h01, 8'hA5); rom_write(8'h02, 8'h1B);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk("ldi_v1", 8'(valid_o), 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk("ldi_v2", 8'(valid_o), 8'h01); chk("ldi_ir", ir_o, 8'h84);
        chk("ldi_imm", imm_o, 8'hA5); chk("ldi_next", imem_addr_o, 8'h02);

        // stall mid-stream
        for (int i = 0; i < 6; i++) rom_write(8'(i), 8'(8'h11 * (i + 1)));
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, 8'h00);
            chk("stall_ir", ir_o, 8'h22); chk("stall_addr", imem_addr_o, 8'h02);
        end
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk("resume_ir", ir_o, 8'h33); chk("resume_pc", pc_o, 8'h02);

        // redirect with stall while in IMM
        rom_write(8'h00, 8'h84); rom_write(8'h40, 8'h2C);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b1, 8'h40);
        chk("redir_v", 8'(valid_o), 8'h00); chk("redir_addr", imem_addr_o, 8'h40);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk("redir_ir", ir_o, 8'h2C); chk("redir_pc", pc_o, 8'h40);

        // halt at 8'hFF with wrap
        rom_write(8'hFF, 8'hF3); rom_write(8'h10, 8'h49);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b1, 8'hFF);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk("hlt_v", 8'(valid_o), 8'h01); chk("hlt_pc", pc_o, 8'hFF);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0, 8'h00);
            chk("halted_v", 8'(valid_o), 8'h00); chk("halted_addr", imem_addr_o, 8'h00);
        end
        step(1'b1, 1'b0, 1'b1, 8'h10);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk("unhalt_ir", ir_o, 8'h49); chk("unhalt_pc", pc_o, 8'h10);

        // reset during IMM
        rom_write(8'h00, 8'h84); rom_write(8'h01, 8'hA5);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h55);
        chk("rimm_addr", imem_addr_o, 8'h00); chk("rimm_ir", ir_o, 8'h00);
        chk("rimm_imm", imm_o, 8'h00); chk("rimm_v", 8'(valid_o), 8'h00);

        // randomized traffic on a random program image
        for (int i = 0; i < 256; i++) rom_write(8'(i), 8'($urandom));
        step(1'b0, 1'b0, 1'b0, 8'h00);
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 99) >= 2),
                 ($urandom_range(0, 99) < 25),
                 ($urandom_range(0, 99) < 8),
                 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
